// File: rtl/fir_avg_out.sv
// Output stage for the 4-tap averaging FIR: drops warm-up samples, divides the tap sum
// by 4 with round-half-up and saturation, and buffers averages in a show-ahead FIFO.
module fir_avg_out #(
   parameter int w     = 16,
   parameter int DEPTH = 4,
   parameter int WARM  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [w+1:0]               s,
   input  logic                       s_valid,
   output logic [w-1:0]               m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int WCW = (WARM > 0) ? $clog2(WARM + 1) : 1;

   localparam logic [WCW-1:0] WARM_L   = WCW'(WARM);
   localparam logic [WCW-1:0] WARM_ONE = WCW'(1);
   localparam logic [LW-1:0]  LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

   // (sum + 2) >> 2 in w+3 bits; only sums beyond the legal FIR range saturate
   function automatic logic [w-1:0] round_sat(input logic [w+1:0] sum);
      logic [w+2:0] t;
      logic [w+2:0] q;
      t = {1'b0, sum} + (w+3)'(2);
      q = t >> 2;
      if (|q[w+2:w]) begin
         round_sat = {w{1'b1}};
      end else begin
         round_sat = q[w-1:0];
      end
   endfunction

   logic [w-1:0]   mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [LW-1:0]  level_r;
   logic [WCW-1:0] warm_cnt_r;
   logic           overflow_r;

   logic           warm_done_s;
   logic           push_req_s;
   logic           full_s;
   logic           pop_s;
   logic           push_s;
   logic           drop_s;
   logic [w-1:0]   avg_s;

   assign warm_done_s = (warm_cnt_r == WARM_L);
   assign push_req_s  = s_valid && warm_done_s;
   assign full_s      = (level_r == LVL_FULL);
   assign m_valid     = (level_r != '0);
   assign pop_s       = m_valid && m_ready;
   // At full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points
   assign push_s      = push_req_s && (!full_s || pop_s);
   assign drop_s      = push_req_s && full_s && !pop_s;
   assign avg_s       = round_sat(s);

   assign m_data   = mem_r[rd_ptr_r];
   assign level    = level_r;
   assign overflow = overflow_r;

   // Warm-up counter: counts discarded samples, then holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt_r <= '0;
      end else if (s_valid && !warm_done_s) begin
         warm_cnt_r <= warm_cnt_r + WARM_ONE;
      end else begin
         warm_cnt_r <= warm_cnt_r;
      end
   end

   // FIFO storage and write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= avg_s;
         wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Read pointer advances on every pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= '0;
      end else if (pop_s) begin
         rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_r <= rd_ptr_r;
      end
   end

   // Occupancy: the single source of full/empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

   // Sticky overflow; a drop wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_ovf) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

endmodule
